// File: rtl/i2s_tx_stereo_if.sv
// Sample-pair stream into the I2S transmitter: one L/R pair per valid/ready transfer.
// The source drives the master side and the transmitter takes the slave side.
interface i2s_tx_stereo_if #(
  parameter int DATA_W = 24
);
  logic              s_valid;
  logic              s_ready;
  logic [DATA_W-1:0] s_left;
  logic [DATA_W-1:0] s_right;

  modport master (output s_valid, output s_left, output s_right, input s_ready);
  modport slave  (input s_valid, input s_left, input s_right, output s_ready);
endinterface

// File: rtl/i2s_tx_stereo.sv
// Stereo I2S / left-justified transmitter: a one-deep holding register feeds a frame register
// that is serialised MSB first; all pin outputs are registered and change on the SCLK falling edge.
module i2s_tx_stereo #(
  parameter int DATA_W        = 24,
  parameter int SLOT_W        = 32,
  parameter int SCLK_DVSR     = 4,
  parameter bit LJ_MODE       = 1'b0,
  parameter bit UNDERRUN_HOLD = 1'b1
) (
  input  logic             clk_i2s,
  input  logic             reset_n,
  i2s_tx_stereo_if.slave   s_if,
  output logic             tx_mclk,
  output logic             tx_sclk,
  output logic             tx_lrclk,
  output logic             tx_sd,
  output logic             underrun,
  output logic             frame_start
);

  localparam int FRAME_BITS = 2 * SLOT_W;
  localparam int BC_W       = $clog2(FRAME_BITS);
  localparam int CNT_W      = $clog2(SCLK_DVSR);
  localparam int IDX_W      = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [BC_W-1:0]   bit_cnt_q, bit_cnt_d;
  logic [DATA_W-1:0] hold_l_q, hold_l_d, hold_r_q, hold_r_d;
  logic              hold_full_q, hold_full_d;
  logic [DATA_W-1:0] frame_l_q, frame_l_d, frame_r_q, frame_r_d;
  logic              sclk_q, sclk_d;
  logic              lrclk_q, lrclk_d;
  logic              sd_q, sd_d;
  logic              underrun_q, underrun_d;
  logic              frame_start_q, frame_start_d;

  logic              tick;
  logic              boundary;
  logic              accept;
  logic [DATA_W-1:0] chan;
  int                slot_pos;
  int                bit_idx;

  always_comb begin
    tick     = (cnt_q == CNT_W'(SCLK_DVSR - 1));
    boundary = tick && (bit_cnt_q == BC_W'(FRAME_BITS - 1));
    accept   = s_if.s_valid && !hold_full_q;

    cnt_d     = tick ? '0 : cnt_q + 1'b1;
    bit_cnt_d = bit_cnt_q;
    if (tick) begin
      bit_cnt_d = boundary ? '0 : bit_cnt_q + 1'b1;
    end

    // An accept coinciding with an empty-holding boundary is not bypassed into the frame.
    frame_l_d = frame_l_q;
    frame_r_d = frame_r_q;
    if (boundary) begin
      if (hold_full_q) begin
        frame_l_d = hold_l_q;
        frame_r_d = hold_r_q;
      end else if (!UNDERRUN_HOLD) begin
        frame_l_d = '0;
        frame_r_d = '0;
      end
    end

    hold_l_d    = accept ? s_if.s_left  : hold_l_q;
    hold_r_d    = accept ? s_if.s_right : hold_r_q;
    hold_full_d = hold_full_q;
    if (boundary && hold_full_q) begin
      hold_full_d = 1'b0;
    end else if (accept) begin
      hold_full_d = 1'b1;
    end

    underrun_d    = boundary && !hold_full_q;
    frame_start_d = boundary;
    sclk_d        = (cnt_d >= CNT_W'(SCLK_DVSR / 2));

    // Pin values are computed from next state so they land on the falling SCLK edge.
    lrclk_d  = (bit_cnt_d >= BC_W'(SLOT_W));
    slot_pos = lrclk_d ? (int'(bit_cnt_d) - SLOT_W) : int'(bit_cnt_d);
    bit_idx  = slot_pos - (LJ_MODE ? 0 : 1);
    chan     = lrclk_d ? frame_r_d : frame_l_d;
    sd_d     = 1'b0;
    if (bit_idx >= 0 && bit_idx < DATA_W) begin
      sd_d = chan[IDX_W'(DATA_W - 1 - bit_idx)];
    end
  end

  always_ff @(posedge clk_i2s or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q         <= '0;
      bit_cnt_q     <= '0;
      hold_l_q      <= '0;
      hold_r_q      <= '0;
      hold_full_q   <= 1'b0;
      frame_l_q     <= '0;
      frame_r_q     <= '0;
      sclk_q        <= 1'b0;
      lrclk_q       <= 1'b0;
      sd_q          <= 1'b0;
      underrun_q    <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      cnt_q         <= cnt_d;
      bit_cnt_q     <= bit_cnt_d;
      hold_l_q      <= hold_l_d;
      hold_r_q      <= hold_r_d;
      hold_full_q   <= hold_full_d;
      frame_l_q     <= frame_l_d;
      frame_r_q     <= frame_r_d;
      sclk_q        <= sclk_d;
      lrclk_q       <= lrclk_d;
      sd_q          <= sd_d;
      underrun_q    <= underrun_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign s_if.s_ready = !hold_full_q;
  assign tx_mclk      = clk_i2s;
  assign tx_sclk      = sclk_q;
  assign tx_lrclk     = lrclk_q;
  assign tx_sd        = sd_q;
  assign underrun     = underrun_q;
  assign frame_start  = frame_start_q;

endmodule

// File: tb/tb_i2s_tx_stereo.sv
// Bench for i2s_tx_stereo: three instances (I2S hold, I2S zero-fill, left-justified 16-bit)
// share clock and reset; a monitor captures each frame at SCLK rising edges for comparison.
module tb_i2s_tx_stereo;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  i2s_tx_stereo_if #(.DATA_W(24)) ifa ();
  i2s_tx_stereo_if #(.DATA_W(24)) ifb ();
  i2s_tx_stereo_if #(.DATA_W(16)) ifc ();

  logic mon_mclk [3];
  logic mon_sclk [3];
  logic mon_lr   [3];
  logic mon_sd   [3];
  logic mon_ur   [3];
  logic mon_fs   [3];

  i2s_tx_stereo #(.DATA_W(24), .SLOT_W(32), .SCLK_DVSR(4), .LJ_MODE(1'b0), .UNDERRUN_HOLD(1'b1)) dut_a (
    .clk_i2s(clk), .reset_n(reset_n), .s_if(ifa),
    .tx_mclk(mon_mclk[0]), .tx_sclk(mon_sclk[0]), .tx_lrclk(mon_lr[0]), .tx_sd(mon_sd[0]),
    .underrun(mon_ur[0]), .frame_start(mon_fs[0]));

  i2s_tx_stereo #(.DATA_W(24), .SLOT_W(32), .SCLK_DVSR(4), .LJ_MODE(1'b0), .UNDERRUN_HOLD(1'b0)) dut_b (
    .clk_i2s(clk), .reset_n(reset_n), .s_if(ifb),
    .tx_mclk(mon_mclk[1]), .tx_sclk(mon_sclk[1]), .tx_lrclk(mon_lr[1]), .tx_sd(mon_sd[1]),
    .underrun(mon_ur[1]), .frame_start(mon_fs[1]));

  i2s_tx_stereo #(.DATA_W(16), .SLOT_W(16), .SCLK_DVSR(8), .LJ_MODE(1'b1), .UNDERRUN_HOLD(1'b1)) dut_c (
    .clk_i2s(clk), .reset_n(reset_n), .s_if(ifc),
    .tx_mclk(mon_mclk[2]), .tx_sclk(mon_sclk[2]), .tx_lrclk(mon_lr[2]), .tx_sd(mon_sd[2]),
    .underrun(mon_ur[2]), .frame_start(mon_fs[2]));

  int total = 0;
  int bad   = 0;
  bit stop  = 1'b0;

  // Frame capture: bit b of a frame is what the pins show at the b-th SCLK rise after frame start.
  logic [63:0] acc_sd  [3];
  logic [63:0] acc_lr  [3];
  logic [63:0] done_sd [3];
  logic [63:0] done_lr [3];
  bit          cur_ur  [3];
  bit          done_ur [3];
  bit          prev_sclk [3];
  int          nbits   [3];
  int          frames  [3];
  int          last_ur [3];
  int          ur_gap  [3];
  int          last_fs [3];
  int          fs_gap  [3];
  int          cyc = 0;

  initial begin
    for (int d = 0; d < 3; d++) begin
      acc_sd[d] = '0; acc_lr[d] = '0; done_sd[d] = '0; done_lr[d] = '0;
      cur_ur[d] = 1'b0; done_ur[d] = 1'b0; prev_sclk[d] = 1'b0;
      nbits[d] = 0; frames[d] = 0; last_ur[d] = 0; ur_gap[d] = 0; last_fs[d] = 0; fs_gap[d] = 0;
    end
  end

  always @(negedge clk) begin
    cyc <= cyc + 1;
    for (int d = 0; d < 3; d++) begin
      prev_sclk[d] <= mon_sclk[d];
      if (!reset_n) begin
        nbits[d]  <= 0;
        cur_ur[d] <= 1'b0;
        acc_sd[d] <= '0;
        acc_lr[d] <= '0;
      end else begin
        if (mon_fs[d]) begin
          done_sd[d] <= acc_sd[d];
          done_lr[d] <= acc_lr[d];
          done_ur[d] <= cur_ur[d];
          cur_ur[d]  <= mon_ur[d];
          frames[d]  <= frames[d] + 1;
          nbits[d]   <= 0;
          acc_sd[d]  <= '0;
          acc_lr[d]  <= '0;
          fs_gap[d]  <= cyc - last_fs[d];
          last_fs[d] <= cyc;
        end else if (mon_sclk[d] && !prev_sclk[d] && nbits[d] < 64) begin
          acc_sd[d][nbits[d]] <= mon_sd[d];
          acc_lr[d][nbits[d]] <= mon_lr[d];
          nbits[d] <= nbits[d] + 1;
        end
        if (mon_ur[d]) begin
          ur_gap[d]  <= cyc - last_ur[d];
          last_ur[d] <= cyc;
        end
      end
    end
  end

  // Reference: frame bit b carries chan[dw-1-i] with i = (b mod slot) - (lj ? 0 : 1).
  function automatic logic [63:0] exp_sd(input int slot, input int dw, input bit lj,
                                         input logic [23:0] l, input logic [23:0] r);
    logic [63:0] v;
    logic [23:0] ch;
    int i;
    v = '0;
    for (int b = 0; b < 2 * slot; b++) begin
      ch = (b >= slot) ? r : l;
      i  = (b % slot) - (lj ? 0 : 1);
      if (i >= 0 && i < dw) v[b] = ch[dw - 1 - i];
    end
    return v;
  endfunction

  function automatic logic [63:0] exp_lr(input int slot);
    logic [63:0] v;
    v = '0;
    for (int b = slot; b < 2 * slot; b++) v[b] = 1'b1;
    return v;
  endfunction

  task automatic wait_frame(input int d);
    int start;
    int guard;
    start = frames[d];
    guard = 0;
    do begin
      @(negedge clk);
      guard++;
    end while (frames[d] == start && guard < 1000);
    if (frames[d] == start) begin
      total++; bad++;
      $display("FAIL frame_timeout dut=%0d got no frame_start in %0d cycles, required one", d, guard);
    end
  endtask

  task automatic test_reset();
    logic [255:0] obs_sclk, exp_sclk, obs_lr, exp_lrv, obs_csclk, exp_csclk, obs_sd, obs_ur, obs_fs, exp_edge;
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    total++;
    if ({mon_sclk[0], mon_lr[0], mon_sd[0], mon_ur[0], mon_fs[0]} !== 5'b0) begin
      bad++; $display("FAIL reset_outputs_a got=%b exp=00000",
                      {mon_sclk[0], mon_lr[0], mon_sd[0], mon_ur[0], mon_fs[0]});
    end
    total++;
    if (ifa.s_ready !== 1'b1) begin bad++; $display("FAIL reset_ready_a got=%b exp=1", ifa.s_ready); end
    total++;
    if ({mon_sclk[1], mon_lr[1], mon_sd[1], mon_ur[1], mon_fs[1], mon_sclk[2], mon_lr[2], mon_sd[2],
         mon_ur[2], mon_fs[2], ifb.s_ready, ifc.s_ready} !== 12'b000000000011) begin
      bad++; $display("FAIL reset_outputs_bc got=%b exp=000000000011",
                      {mon_sclk[1], mon_lr[1], mon_sd[1], mon_ur[1], mon_fs[1], mon_sclk[2], mon_lr[2],
                       mon_sd[2], mon_ur[2], mon_fs[2], ifb.s_ready, ifc.s_ready});
    end
    total++;
    if (mon_mclk[0] !== clk) begin bad++; $display("FAIL mclk got=%b exp=%b", mon_mclk[0], clk); end

    reset_n = 1'b1;
    exp_edge = '0;
    exp_edge[255] = 1'b1;
    for (int j = 1; j <= 256; j++) begin
      @(negedge clk);
      obs_sclk[j-1]  = mon_sclk[0];  exp_sclk[j-1]  = ((j % 4) >= 2);
      obs_lr[j-1]    = mon_lr[0];    exp_lrv[j-1]   = ((j % 256) >= 128);
      obs_csclk[j-1] = mon_sclk[2];  exp_csclk[j-1] = ((j % 8) >= 4);
      obs_sd[j-1]    = mon_sd[0];
      obs_ur[j-1]    = mon_ur[0];
      obs_fs[j-1]    = mon_fs[0];
    end
    total++;
    if (obs_sclk !== exp_sclk) begin bad++; $display("FAIL sclk_wave got=%h exp=%h", obs_sclk, exp_sclk); end
    total++;
    if (obs_lr !== exp_lrv) begin bad++; $display("FAIL lrclk_wave got=%h exp=%h", obs_lr, exp_lrv); end
    total++;
    if (obs_csclk !== exp_csclk) begin bad++; $display("FAIL sclk_wave_lj got=%h exp=%h", obs_csclk, exp_csclk); end
    total++;
    if (obs_sd !== 256'b0) begin bad++; $display("FAIL first_frame_sd got=%h exp=0", obs_sd); end
    total++;
    if (obs_ur !== exp_edge) begin bad++; $display("FAIL first_frame_underrun got=%h exp=%h", obs_ur, exp_edge); end
    total++;
    if (obs_fs !== exp_edge) begin bad++; $display("FAIL first_frame_start got=%h exp=%h", obs_fs, exp_edge); end
    $display("reset: waveforms sampled for 256 cycles");
  endtask

  task automatic test_single_pair();
    logic [63:0] e;
    wait_frame(0);
    ifa.s_valid = 1'b1; ifa.s_left = 24'hA5A5A5; ifa.s_right = 24'h5A5A5A;
    @(posedge clk); #1;
    ifa.s_valid = 1'b0;
    @(negedge clk);
    total++;
    if (ifa.s_ready !== 1'b0) begin bad++; $display("FAIL ready_after_accept got=%b exp=0", ifa.s_ready); end
    wait_frame(0);
    wait_frame(0);
    e = exp_sd(32, 24, 1'b0, 24'hA5A5A5, 24'h5A5A5A);
    total++;
    if (done_sd[0] !== e) begin bad++; $display("FAIL pair_sd got=%h exp=%h", done_sd[0], e); end
    total++;
    if (done_lr[0] !== exp_lr(32)) begin bad++; $display("FAIL pair_lr got=%h exp=%h", done_lr[0], exp_lr(32)); end
    total++;
    if (done_ur[0] !== 1'b0) begin bad++; $display("FAIL pair_underrun got=%b exp=0", done_ur[0]); end
    $display("single_pair: L=a5a5a5 R=5a5a5a sd=%h", done_sd[0]);
  endtask

  task automatic test_back_to_back();
    logic [47:0] sent[$];
    logic [47:0] p;
    logic [63:0] e;
    int accepts;
    accepts = 0;
    stop = 1'b0;
    fork
      begin
        int guard;
        guard = 0;
        ifa.s_left  = 24'($urandom);
        ifa.s_right = 24'($urandom);
        ifa.s_valid = 1'b1;
        while (!stop && guard < 3000) begin
          if (ifa.s_ready) begin
            if (accepts > 0) begin
              total++;
              if (mon_fs[0] !== 1'b1) begin
                bad++; $display("FAIL ready_rise_at_boundary accept=%0d frame_start=%b exp=1", accepts, mon_fs[0]);
              end
            end
            sent.push_back({ifa.s_left, ifa.s_right});
            accepts++;
            @(posedge clk); #1;
            ifa.s_left  = 24'($urandom);
            ifa.s_right = 24'($urandom);
          end
          @(negedge clk);
          guard++;
        end
        ifa.s_valid = 1'b0;
      end
      begin
        wait_frame(0);
        for (int n = 0; n < 4; n++) begin
          wait_frame(0);
          if (sent.size() > 0) p = sent.pop_front(); else p = 48'hx;
          e = exp_sd(32, 24, 1'b0, p[47:24], p[23:0]);
          total++;
          if (done_sd[0] !== e) begin bad++; $display("FAIL b2b_sd frame=%0d got=%h exp=%h", n, done_sd[0], e); end
          total++;
          if (done_ur[0] !== 1'b0) begin bad++; $display("FAIL b2b_underrun frame=%0d got=%b exp=0", n, done_ur[0]); end
          $display("back_to_back: frame %0d L=%h R=%h sd=%h", n, p[47:24], p[23:0], done_sd[0]);
        end
        stop = 1'b1;
      end
    join
    total++;
    if (accepts !== 6) begin bad++; $display("FAIL b2b_accept_count got=%0d exp=6", accepts); end
  endtask

  task automatic test_underrun_modes();
    logic [23:0] l, r;
    logic [63:0] e;
    wait_frame(0);
    wait_frame(0);
    l = 24'($urandom); r = 24'($urandom);
    ifa.s_left = l; ifa.s_right = r; ifa.s_valid = 1'b1;
    ifb.s_left = l; ifb.s_right = r; ifb.s_valid = 1'b1;
    @(posedge clk); #1;
    ifa.s_valid = 1'b0; ifb.s_valid = 1'b0;
    wait_frame(0);
    wait_frame(0);
    e = exp_sd(32, 24, 1'b0, l, r);
    total++;
    if (done_sd[0] !== e || done_sd[1] !== e) begin
      bad++; $display("FAIL hold_first got_a=%h got_b=%h exp=%h", done_sd[0], done_sd[1], e);
    end
    for (int n = 0; n < 2; n++) begin
      wait_frame(0);
      total++;
      if (done_sd[0] !== e) begin bad++; $display("FAIL hold1_replay n=%0d got=%h exp=%h", n, done_sd[0], e); end
      total++;
      if (done_sd[1] !== 64'h0) begin bad++; $display("FAIL hold0_zero n=%0d got=%h exp=0", n, done_sd[1]); end
      total++;
      if ({done_ur[0], done_ur[1]} !== 2'b11) begin
        bad++; $display("FAIL underrun_flag n=%0d got=%b exp=11", n, {done_ur[0], done_ur[1]});
      end
      $display("underrun: n=%0d hold1=%h hold0=%h", n, done_sd[0], done_sd[1]);
    end
    total++;
    if (ur_gap[0] !== 256 || ur_gap[1] !== 256) begin
      bad++; $display("FAIL underrun_period got_a=%0d got_b=%0d exp=256", ur_gap[0], ur_gap[1]);
    end
  endtask

  task automatic test_left_justified();
    logic [15:0] r;
    logic [63:0] e;
    wait_frame(2);
    r = 16'($urandom);
    ifc.s_left = 16'h8001; ifc.s_right = r; ifc.s_valid = 1'b1;
    @(posedge clk); #1;
    ifc.s_valid = 1'b0;
    wait_frame(2);
    wait_frame(2);
    e = exp_sd(16, 16, 1'b1, 24'h008001, {8'h00, r});
    total++;
    if (done_sd[2] !== e) begin bad++; $display("FAIL lj_sd got=%h exp=%h", done_sd[2], e); end
    total++;
    if ({done_sd[2][0], done_sd[2][15], done_sd[2][1]} !== 3'b110) begin
      bad++; $display("FAIL lj_msb_lsb got=%b exp=110", {done_sd[2][0], done_sd[2][15], done_sd[2][1]});
    end
    total++;
    if (done_lr[2] !== exp_lr(16)) begin bad++; $display("FAIL lj_lr got=%h exp=%h", done_lr[2], exp_lr(16)); end
    total++;
    if (fs_gap[2] !== 256) begin bad++; $display("FAIL lj_frame_len got=%0d exp=256", fs_gap[2]); end
    $display("left_justified: L=8001 R=%h sd=%h", r, done_sd[2]);
  endtask

  task automatic test_reset_mid_frame();
    wait_frame(0);
    ifa.s_left = 24'($urandom) | 24'h800001; ifa.s_right = 24'($urandom); ifa.s_valid = 1'b1;
    @(posedge clk); #1;
    ifa.s_valid = 1'b0;
    repeat (40) @(negedge clk);
    total++;
    if (ifa.s_ready !== 1'b0) begin bad++; $display("FAIL mid_holding_full got=%b exp=0", ifa.s_ready); end
    #2 reset_n = 1'b0;
    #1;
    total++;
    if ({mon_sclk[0], mon_lr[0], mon_sd[0], mon_ur[0], mon_fs[0], ifa.s_ready} !== 6'b000001) begin
      bad++; $display("FAIL async_reset got=%b exp=000001",
                      {mon_sclk[0], mon_lr[0], mon_sd[0], mon_ur[0], mon_fs[0], ifa.s_ready});
    end
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    wait_frame(0);
    total++;
    if (done_sd[0] !== 64'h0 || done_ur[0] !== 1'b0) begin
      bad++; $display("FAIL post_reset_frame0 got_sd=%h got_ur=%b exp=0/0", done_sd[0], done_ur[0]);
    end
    wait_frame(0);
    total++;
    if (done_sd[0] !== 64'h0 || done_ur[0] !== 1'b1) begin
      bad++; $display("FAIL pending_discarded got_sd=%h got_ur=%b exp=0/1", done_sd[0], done_ur[0]);
    end
    $display("reset_mid_frame: frames after release sd=%h underrun=%b", done_sd[0], done_ur[0]);
  endtask

  initial begin
    ifa.s_valid = 1'b0; ifa.s_left = '0; ifa.s_right = '0;
    ifb.s_valid = 1'b0; ifb.s_left = '0; ifb.s_right = '0;
    ifc.s_valid = 1'b0; ifc.s_left = '0; ifc.s_right = '0;
    test_reset();
    test_single_pair();
    test_back_to_back();
    test_underrun_modes();
    test_left_justified();
    test_reset_mid_frame();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
